cabac_sig_ctx_gen: RTL
======================

CABAC_SIG_CTX_GEN -- requirements
Module: cabac_sig_ctx_gen

Interface
REQ-001 Parameter LANES, default 4, meaning contexts emitted per beat; legal values 1, 2, 4.
REQ-002 Parameter ADDR_BASE, default 9'h02c, meaning context-RAM base of sig_coeff_flag.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cg_valid_i / cg_ready_o  in/out  1  CG request handshake.
REQ-006 cg_x_i, cg_y_i  input  3 each  CG coordinates in TU.
REQ-007 cg_right_i, cg_below_i  input  1 each  coded_sub_block_flag of right/below neighbour CG.
REQ-008 scan_idx_i 2, tu_depth_i 2, coeff_type_i 2  input  scan (`SCAN_DIAG/HOR/VER), 3=4x4..0=32x32, coeff_type_i[1]=1 luma.
REQ-009 start_idx_i  input  4  first in-CG scan position to emit; emission runs start_idx_i down to 0.
REQ-010 ctx_valid_o / ctx_ready_i  out/in  1  beat handshake.
REQ-011 ctx_addr_o  output  9*LANES  lane k at bits [9k+8:9k].
REQ-012 ctx_lane_en_o  output  LANES  lane k holds a valid position.
REQ-013 ctx_pos_o  output  4  scan position of lane 0; ctx_last_o  output  1  final beat of the CG.

Function
REQ-014 FSM states IDLE, RUN; cg_ready_o SHALL be 1 in IDLE, or in RUN when the final beat is handshaken that cycle.
REQ-015 On cg_valid_i&&cg_ready_o, all CG inputs SHALL be latched; cnt<=start_idx_i; state<=RUN.
REQ-016 ctx_valid_o SHALL equal (state==RUN); first beat valid the cycle after acceptance.
REQ-017 Lane k SHALL carry position cnt-k; lane_en[k]=(cnt>=k); ctx_pos_o=cnt; ctx_last_o=(cnt<LANES).
REQ-018 Beat handshake with ctx_last_o=0: cnt<=cnt-LANES; with ctx_last_o=1: state<=IDLE unless a new CG is accepted the same cycle (back-to-back, no bubble).
REQ-019 Outputs SHALL hold stable while ctx_valid_o&&!ctx_ready_i.
REQ-020 In-CG (x,y) from position via 4x4 scan table for scan_idx_i; pos_x={cg_x,x}, pos_y={cg_y,y}.
REQ-021 pattern={cg_below,cg_right}; cnt_sig: pat0: x+y==0→2, x+y<3→1, else 0; pat1: y==0→2, y==1→1, else 0; pat2: same on x; pat3: 2.
REQ-022 sig: pos (0,0)→0; tu_depth 3→ctxIndMap[4y+x]={0,1,4,5,2,3,4,5,6,6,8,8,7,7,8,8}; else base+cnt_sig+offset, base=3 if luma and CG≠(0,0) else 0, offset=tu_depth2?(diag?9:15):(luma?21:12).
REQ-023 ctx_addr = ADDR_BASE + sig + (luma?0:27), 9-bit, no overflow possible; disabled lanes SHALL drive 0.

Reset
REQ-024 rst_n low SHALL force state IDLE, cnt 0, latched fields 0, ctx_valid_o 0, ctx_addr_o 0, ctx_lane_en_o 0, ctx_last_o 0, cg_ready_o 1 after release.
REQ-025 Reset mid-RUN SHALL abandon the CG; no beat emitted after release until a new acceptance.

Configuration
REQ-026 Macro CABAC_SIG_CTX_STAT_EN defined: add outputs stall_cnt_o[31:0] (cycles ctx_valid_o&&!ctx_ready_i) and beat_cnt_o[31:0] (handshaken beats), wrapping, reset to 0.
REQ-027 Macro undefined: those ports and counters SHALL not exist; function otherwise identical.

Structure
REQ-028 Shared package/defines: 4x4 diag/hor/ver scan tables, ctxIndMap table, offsets 9/15/21/12, chroma offset 27, `SCAN_* codes.
REQ-029 One sub-module cabac_sig_ctx_lane (pure combinational per-position address), instantiated LANES times.

Verification
REQ-030 4x4 luma diag, start 15, LANES 4, ready=1 -> beat0 addrs {0x34,0x34,0x34,0x31}, lane_en 1111, pos 15; 4 beats, last on 4th.
REQ-031 8x8 luma diag, CG(1,0), right=below=0, start 0 -> one beat, lane0 0x3a, lane_en 0001, last 1.
REQ-032 16x16 chroma (depth 1), CG(0,0), pattern 3, diag, start 2 -> lanes pos 2,1,0 = (1,0)→0x55, (0,1)→0x55, DC→0x47, lane_en 0111.
REQ-033 ctx_ready_i low 5 cycles mid-CG -> outputs frozen, no position lost or repeated; with STAT_EN stall_cnt_o=5.
REQ-034 Two CGs back-to-back, cg_valid_i held -> second accepted on first's final beat, no idle cycle on ctx_valid_o.
REQ-035 rst_n asserted in RUN -> ctx_valid_o 0 asynchronously; after release, IDLE, cg_ready_o 1.

Source files
------------

// File: rtl/cabac_sig_ctx_gen_pkg.sv
// Shared scan/context tables and constants for the sig_coeff_flag context generator.
// Scan codes are exported both as `SCAN_* macros and as package localparams.
`ifndef CABAC_SIG_CTX_DEFINES
`define CABAC_SIG_CTX_DEFINES
`define SCAN_DIAG 2'd0
`define SCAN_HOR  2'd1
`define SCAN_VER  2'd2
`endif

package cabac_sig_ctx_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Everything about a CG that the per-position address depends on.
  typedef struct packed {
    logic [1:0] scan;
    logic [1:0] depth;
    logic       luma;
    logic [2:0] cg_x;
    logic [2:0] cg_y;
    logic [1:0] pattern;
  } cg_req_t;

  localparam logic [1:0] SCAN_DIAG_C = `SCAN_DIAG;
  localparam logic [1:0] SCAN_HOR_C  = `SCAN_HOR;
  localparam logic [1:0] SCAN_VER_C  = `SCAN_VER;

  localparam logic [1:0] DEPTH_4X4     = 2'd3;
  localparam logic [1:0] DEPTH_8X8     = 2'd2;
  localparam logic [4:0] OFS_8X8_DIAG  = 5'd9;
  localparam logic [4:0] OFS_8X8_OTHER = 5'd15;
  localparam logic [4:0] OFS_LUMA_BIG  = 5'd21;
  localparam logic [4:0] OFS_CHROMA    = 5'd12;
  localparam logic [4:0] LUMA_CG_BASE  = 5'd3;
  localparam logic [8:0] CHROMA_OFS    = 9'd27;

  // Returns {x[1:0], y[1:0]} of an in-CG scan position.
  function automatic logic [3:0] scan_xy(input logic [1:0] scan, input logic [3:0] pos);
    logic [3:0] xy;
    xy = 4'd0;
    case (scan)
      SCAN_HOR_C: xy = {pos[1:0], pos[3:2]};
      SCAN_VER_C: xy = {pos[3:2], pos[1:0]};
      default: begin
        case (pos)
          4'd0:    xy = 4'h0;
          4'd1:    xy = 4'h1;
          4'd2:    xy = 4'h4;
          4'd3:    xy = 4'h2;
          4'd4:    xy = 4'h5;
          4'd5:    xy = 4'h8;
          4'd6:    xy = 4'h3;
          4'd7:    xy = 4'h6;
          4'd8:    xy = 4'h9;
          4'd9:    xy = 4'hc;
          4'd10:   xy = 4'h7;
          4'd11:   xy = 4'ha;
          4'd12:   xy = 4'hd;
          4'd13:   xy = 4'hb;
          4'd14:   xy = 4'he;
          4'd15:   xy = 4'hf;
          default: xy = 4'h0;
        endcase
      end
    endcase
    return xy;
  endfunction

  function automatic logic [3:0] ctx_ind_map(input logic [3:0] idx);
    logic [3:0] m;
    m = 4'd0;
    case (idx)
      4'd0:    m = 4'd0;
      4'd1:    m = 4'd1;
      4'd2:    m = 4'd4;
      4'd3:    m = 4'd5;
      4'd4:    m = 4'd2;
      4'd5:    m = 4'd3;
      4'd6:    m = 4'd4;
      4'd7:    m = 4'd5;
      4'd8:    m = 4'd6;
      4'd9:    m = 4'd6;
      4'd10:   m = 4'd8;
      4'd11:   m = 4'd8;
      4'd12:   m = 4'd7;
      4'd13:   m = 4'd7;
      4'd14:   m = 4'd8;
      4'd15:   m = 4'd8;
      default: m = 4'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cabac_sig_ctx_gen_lane.sv
// Combinational context-RAM address of sig_coeff_flag for one scan position of the current CG.
module cabac_sig_ctx_lane
  import cabac_sig_ctx_gen_pkg::*;
#(
  parameter logic [8:0] ADDR_BASE = 9'h02c
) (
  input  logic       en_i,
  input  logic [3:0] pos_i,
  input  logic [1:0] scan_i,
  input  logic [1:0] depth_i,
  input  logic       luma_i,
  input  logic [2:0] cg_x_i,
  input  logic [2:0] cg_y_i,
  input  logic [1:0] pattern_i,
  output logic [8:0] addr_o
);

  logic [3:0] xy_s;
  logic [1:0] x_s;
  logic [1:0] y_s;
  logic [2:0] xy_sum_s;
  logic       cg_zero_s;
  logic [1:0] cnt_sig_s;
  logic [4:0] base_s;
  logic [4:0] offset_s;
  logic [4:0] sig_s;

  // Position -> neighbour-pattern count -> sig context -> RAM address.
  always_comb begin
    xy_s      = scan_xy(scan_i, pos_i);
    x_s       = xy_s[3:2];
    y_s       = xy_s[1:0];
    xy_sum_s  = {1'b0, x_s} + {1'b0, y_s};
    cg_zero_s = (cg_x_i == 3'd0) && (cg_y_i == 3'd0);
    cnt_sig_s = 2'd0;
    case (pattern_i)
      2'd0: begin
        if (xy_sum_s == 3'd0)     cnt_sig_s = 2'd2;
        else if (xy_sum_s < 3'd3) cnt_sig_s = 2'd1;
        else                      cnt_sig_s = 2'd0;
      end
      2'd1: begin
        if (y_s == 2'd0)      cnt_sig_s = 2'd2;
        else if (y_s == 2'd1) cnt_sig_s = 2'd1;
        else                  cnt_sig_s = 2'd0;
      end
      2'd2: begin
        if (x_s == 2'd0)      cnt_sig_s = 2'd2;
        else if (x_s == 2'd1) cnt_sig_s = 2'd1;
        else                  cnt_sig_s = 2'd0;
      end
      default: cnt_sig_s = 2'd2;
    endcase

    if (luma_i && !cg_zero_s) base_s = LUMA_CG_BASE;
    else                      base_s = 5'd0;

    if (depth_i == DEPTH_8X8) offset_s = (scan_i == SCAN_DIAG_C) ? OFS_8X8_DIAG : OFS_8X8_OTHER;
    else                      offset_s = luma_i ? OFS_LUMA_BIG : OFS_CHROMA;

    // 4x4 TUs use the fixed map; elsewhere the global DC position is context 0.
    if (depth_i == DEPTH_4X4)                       sig_s = {1'b0, ctx_ind_map({y_s, x_s})};
    else if (cg_zero_s && (xy_sum_s == 3'd0))      sig_s = 5'd0;
    else                                            sig_s = base_s + {3'd0, cnt_sig_s} + offset_s;

    if (en_i) addr_o = ADDR_BASE + {4'd0, sig_s} + (luma_i ? 9'd0 : CHROMA_OFS);
    else      addr_o = 9'd0;
  end

endmodule

// File: rtl/cabac_sig_ctx_gen.sv
// Streams sig_coeff_flag context addresses for one CG, LANES positions per beat, scan order high to low.
// Optional CABAC_SIG_CTX_STAT_EN adds stall/beat counters.
module cabac_sig_ctx_gen
  import cabac_sig_ctx_gen_pkg::*;
#(
  parameter int         LANES     = 4,
  parameter logic [8:0] ADDR_BASE = 9'h02c
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cg_valid_i,
  output logic                 cg_ready_o,
  input  logic [2:0]           cg_x_i,
  input  logic [2:0]           cg_y_i,
  input  logic                 cg_right_i,
  input  logic                 cg_below_i,
  input  logic [1:0]           scan_idx_i,
  input  logic [1:0]           tu_depth_i,
  input  logic [1:0]           coeff_type_i,
  input  logic [3:0]           start_idx_i,
  output logic                 ctx_valid_o,
  input  logic                 ctx_ready_i,
  output logic [9*LANES-1:0]   ctx_addr_o,
  output logic [LANES-1:0]     ctx_lane_en_o,
  output logic [3:0]           ctx_pos_o,
  output logic                 ctx_last_o
`ifdef CABAC_SIG_CTX_STAT_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          beat_cnt_o
`endif
);

  localparam logic [3:0] LANES_W = 4'(LANES);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  cg_req_t              req_q, req_d, req_in_s;
  logic [9*LANES-1:0]   addr_q, addr_d;
  logic [LANES-1:0]     lane_en_q, lane_en_d;
  logic                 last_q, last_d;
  logic                 accept_s;
  logic                 beat_s;
  logic                 unused_coeff_s;

  assign unused_coeff_s = coeff_type_i[0];

  assign req_in_s = '{scan: scan_idx_i, depth: tu_depth_i, luma: coeff_type_i[1],
                      cg_x: cg_x_i, cg_y: cg_y_i, pattern: {cg_below_i, cg_right_i}};

  assign ctx_valid_o   = (state_q == ST_RUN);
  assign beat_s        = ctx_valid_o && ctx_ready_i;
  assign cg_ready_o    = (state_q == ST_IDLE) || (beat_s && last_q);
  assign accept_s      = cg_valid_i && cg_ready_o;
  assign ctx_addr_o    = addr_q;
  assign ctx_lane_en_o = lane_en_q;
  assign ctx_pos_o     = cnt_q;
  assign ctx_last_o    = last_q;

  // Next-state: accept a CG, step the position counter per beat, chain CGs without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          cnt_d   = start_idx_i;
          req_d   = req_in_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_s && !last_q) begin
          cnt_d = cnt_q - LANES_W;
        end else if (beat_s && accept_s) begin
          cnt_d = start_idx_i;
          req_d = req_in_s;
        end else if (beat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_d = (state_d == ST_RUN) && (cnt_d < LANES_W);
  end

  // Lanes look at next-state values so the beat outputs can be registered.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [4:0] diff_s;
    logic       en_s;
    assign diff_s       = {1'b0, cnt_d} - 5'(k);
    assign en_s         = (state_d == ST_RUN) && !diff_s[4];
    assign lane_en_d[k] = en_s;

    cabac_sig_ctx_lane #(
      .ADDR_BASE (ADDR_BASE)
    ) u_lane (
      .en_i      (en_s),
      .pos_i     (diff_s[3:0]),
      .scan_i    (req_d.scan),
      .depth_i   (req_d.depth),
      .luma_i    (req_d.luma),
      .cg_x_i    (req_d.cg_x),
      .cg_y_i    (req_d.cg_y),
      .pattern_i (req_d.pattern),
      .addr_o    (addr_d[9*k +: 9])
    );
  end

  // State, counter, latched CG fields and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      req_q     <= '0;
      addr_q    <= '0;
      lane_en_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      lane_en_q <= lane_en_d;
      last_q    <= last_d;
    end
  end

`ifdef CABAC_SIG_CTX_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Free-running (wrapping) stall and beat counters.
  always_comb begin
    if (ctx_valid_o && !ctx_ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
    else                             stall_cnt_d = stall_cnt_q;
    if (beat_s) beat_cnt_d = beat_cnt_q + 32'd1;
    else        beat_cnt_d = beat_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      beat_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign beat_cnt_o  = beat_cnt_q;
`endif

endmodule
